// File: rtl/dualmem_port_arb.sv
// Two-requester round-robin front end for a single-port RAM, with a
// zero-fill engine that sweeps the whole array after reset or on request.
module dualmem_port_arb #(
  parameter int unsigned AW             = 9,
  parameter int unsigned DW             = 64,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  output logic                     busy_o,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [1:0][AW-1:0]       req_addr_i,
  input  logic [1:0][DW/8-1:0]     req_we_i,
  input  logic [1:0][DW-1:0]       req_wdata_i,
  output logic [1:0]               rsp_valid_o,
  output logic [DW-1:0]            rsp_rdata_o,
  output logic                     mem_en_o,
  output logic [DW/8-1:0]          mem_we_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_wdata_o,
  input  logic [DW-1:0]            mem_rdata_i
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic            rsp_read_q, rsp_read_d;

  logic            gnt_idx;
  logic [1:0]      grant_c;
  logic            busy_c;
  logic            mem_en_c;
  logic [BW-1:0]   mem_we_c;

  // State, clear counter, priority pointer and response pipeline
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_read_q  <= rsp_read_d;
    end
  end

  // prio_q names the requester that wins when both are valid
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    rsp_valid_d = '0;
    rsp_read_d  = 1'b0;
    grant_c     = '0;
    busy_c      = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    gnt_idx     = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];

    case (state_q)
      ST_CLEAR: begin
        busy_c     = 1'b1;
        mem_en_c   = 1'b1;
        mem_we_c   = '1;
        mem_addr_o = cnt_q;
        if (cnt_q == '1) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
        end
        // A grant in the clear_i cycle still completes; its response lands in CLEAR
        if (req_valid_i != 2'b00) begin
          grant_c[gnt_idx] = 1'b1;
          prio_d           = ~gnt_idx;
          mem_en_c         = 1'b1;
          mem_we_c         = req_we_i[gnt_idx];
          mem_addr_o       = req_addr_i[gnt_idx];
          mem_wdata_o      = req_wdata_i[gnt_idx];
          rsp_valid_d      = grant_c;
          rsp_read_d       = (req_we_i[gnt_idx] == '0);
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Control outputs are forced quiet while reset is held
  always_comb begin
    busy_o      = busy_c & rst_ni;
    mem_en_o    = mem_en_c & rst_ni;
    mem_we_o    = mem_we_c & {BW{rst_ni}};
    req_ready_o = grant_c & {2{rst_ni}};
    rsp_valid_o = rsp_valid_q;
    rsp_rdata_o = rsp_read_q ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_dualmem_port_arb.sv
// Scoreboard bench for dualmem_port_arb: directed requests push expected
// responses; a monitor pops them whenever a response strobe appears.
module tb_dualmem_port_arb;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned NW = 1 << AW;

  typedef struct packed {
    logic [1:0]    vld;
    logic [DW-1:0] data;
  } rsp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 clear_i;
  logic                 busy_o;
  logic [1:0]           req_valid_i;
  logic [1:0]           req_ready_o;
  logic [1:0][AW-1:0]   req_addr_i;
  logic [1:0][BW-1:0]   req_we_i;
  logic [1:0][DW-1:0]   req_wdata_i;
  logic [1:0]           rsp_valid_o;
  logic [DW-1:0]        rsp_rdata_o;
  logic                 mem_en_o;
  logic [BW-1:0]        mem_we_o;
  logic [AW-1:0]        mem_addr_o;
  logic [DW-1:0]        mem_wdata_o;
  logic [DW-1:0]        mem_rdata_i;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  logic [DW-1:0] ram [NW];

  localparam logic [DW-1:0] PAT0 = 64'h1111_2222_3333_4440;

  dualmem_port_arb #(.AW(AW), .DW(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .busy_o      (busy_o),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port RAM, pre-filled with garbage so the zero-fill matters
  initial begin
    for (int i = 0; i < NW; i++) ram[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    mem_rdata_i = '0;
  end

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      mem_rdata_i <= ram[mem_addr_o];
      for (int b = 0; b < BW; b++) begin
        if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rsp_valid_o != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %b expected none", rsp_valid_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid_o), 64'(mon_e.vld));
        chk("rsp_rdata", 64'(rsp_rdata_o), 64'(mon_e.data));
      end
    end
  end

  task automatic chk_reset_outputs(input string name);
    chk({name, " busy"},      64'(busy_o),      64'(0));
    chk({name, " mem_en"},    64'(mem_en_o),    64'(0));
    chk({name, " mem_we"},    64'(mem_we_o),    64'(0));
    chk({name, " ready"},     64'(req_ready_o), 64'(0));
    chk({name, " rsp_valid"}, 64'(rsp_valid_o), 64'(0));
    chk({name, " rsp_rdata"}, 64'(rsp_rdata_o), 64'(0));
  endtask

  task automatic chk_clear_cycle(input string name, input int k);
    chk({name, " busy"},  64'(busy_o),      64'(1));
    chk({name, " en"},    64'(mem_en_o),    64'(1));
    chk({name, " we"},    64'(mem_we_o),    64'(8'hFF));
    chk({name, " addr"},  64'(mem_addr_o),  64'(k));
    chk({name, " wdata"}, 64'(mem_wdata_o), 64'(0));
    chk({name, " ready"}, 64'(req_ready_o), 64'(0));
  endtask

  task automatic step_req(input logic clr, input logic [1:0] vld,
                          input logic [AW-1:0] a0, input logic [BW-1:0] w0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [BW-1:0] w1, input logic [DW-1:0] d1,
                          input logic [1:0] exp_rdy, input logic [DW-1:0] exp_rd, input string name);
    rsp_t e;
    @(negedge clk_i);
    clear_i        = clr;
    req_valid_i    = vld;
    req_addr_i[0]  = a0;  req_we_i[0] = w0;  req_wdata_i[0] = d0;
    req_addr_i[1]  = a1;  req_we_i[1] = w1;  req_wdata_i[1] = d1;
    #1;
    chk({name, " ready"}, 64'(req_ready_o), 64'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      chk({name, " mem_en"},    64'(mem_en_o),    64'(1));
      chk({name, " mem_addr"},  64'(mem_addr_o),  64'(exp_rdy[1] ? a1 : a0));
      chk({name, " mem_we"},    64'(mem_we_o),    64'(exp_rdy[1] ? w1 : w0));
      chk({name, " mem_wdata"}, 64'(mem_wdata_o), 64'(exp_rdy[1] ? d1 : d0));
      e.vld  = exp_rdy;
      e.data = exp_rd;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk_i);
    clear_i     = 1'b0;
    req_valid_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    req_valid_i = 2'b11;
    req_addr_i  = '0;
    req_we_i    = '0;
    req_wdata_i = '0;

    repeat (3) @(negedge clk_i);
    #1 chk_reset_outputs("reset");

    // Power-on zero-fill: addresses 0..511, requests held off
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 chk_clear_cycle("init_clear", 0);
    for (int k = 1; k < NW; k++) begin
      @(negedge clk_i);
      #1 chk_clear_cycle("init_clear", k);
      if (k == NW - 1) req_valid_i = 2'b00;
    end
    @(negedge clk_i);
    #1 chk("init_done busy", 64'(busy_o), 64'(0));
    chk("init_done mem_en", 64'(mem_en_o), 64'(0));

    step_req(1'b0, 2'b01, 9'h1FF, 8'h00, '0, '0, '0, '0, 2'b01, 64'h0, "read_top");

    // Byte-masked write then read-back
    step_req(1'b0, 2'b01, 9'd5, 8'h0F, 64'h0123_4567_89AB_CDEF, '0, '0, '0, 2'b01, 64'h0, "wr5");
    step_req(1'b0, 2'b01, 9'd5, 8'h00, '0, '0, '0, '0, 2'b01, 64'h0000_0000_89AB_CDEF, "rd5");

    // Only requester 1 valid: granted every cycle
    for (int i = 0; i < 3; i++)
      step_req(1'b0, 2'b10, '0, '0, '0, 9'(10 + i), 8'hFF, PAT0 + 64'(i), 2'b10, 64'h0, "solo1");

    // Both valid: strict alternation starting with requester 0
    for (int i = 0; i < 6; i++)
      step_req(1'b0, 2'b11, 9'd5, 8'h00, '0, 9'd10, 8'h00, '0,
               (i % 2 == 0) ? 2'b01 : 2'b10,
               (i % 2 == 0) ? 64'h0000_0000_89AB_CDEF : PAT0, "rr");
    idle();

    // Grant in the clear_i cycle completes; re-pulsing clear_i does not extend
    step_req(1'b1, 2'b01, 9'd10, 8'h00, '0, '0, '0, '0, 2'b01, PAT0, "rd_clr");
    for (int k = 0; k < NW; k++) begin
      @(negedge clk_i);
      if (k == 0) begin clear_i = 1'b0; req_valid_i = 2'b00; end
      if (k == 5) clear_i = 1'b1;
      if (k == 6) clear_i = 1'b0;
      #1;
      chk("rt_clear busy", 64'(busy_o), 64'(1));
      chk("rt_clear addr", 64'(mem_addr_o), 64'(k));
    end
    @(negedge clk_i);
    #1 chk("rt_clear_done busy", 64'(busy_o), 64'(0));

    step_req(1'b0, 2'b01, 9'd10, 8'h00, '0, '0, '0, '0, 2'b01, 64'h0, "rd_after_clr");
    idle();

    // Reset in the middle of a sweep aborts it; sweep restarts from 0
    @(negedge clk_i);
    clear_i = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk_i);
      if (k == 0) clear_i = 1'b0;
    end
    #1 chk("mid_clear addr", 64'(mem_addr_o), 64'(100));
    req_valid_i = 2'b11;
    rst_ni = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 chk_clear_cycle("restart", 0);
    req_valid_i = 2'b00;
    for (int k = 1; k < NW; k++) @(negedge clk_i);
    #1 chk("restart last addr", 64'(mem_addr_o), 64'(NW - 1));
    @(negedge clk_i);
    #1 chk("restart_done busy", 64'(busy_o), 64'(0));

    repeat (2) @(negedge clk_i);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
